// File: rtl/mem_fe_pkg.sv
// Shared types and constants for the memory request front end.
// MEM_REQ_FRONTEND_STATS_EN enables the issue counters in mem_req_frontend.
package mem_fe_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int ADDR_WIDTH  = 4;
    localparam int STATS_WIDTH = 16;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RD_WAIT,
        ST_RSP
    } fe_state_e;

    function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Request buffer: power-of-two FIFO with unreset storage and async-reset pointers.
// A push is taken on a full FIFO when a pop happens in the same cycle.
module mem_req_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      cnt_q;
    logic             do_push, do_pop;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == FULL_CNT);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/mem_req_frontend.sv
// In-order memory request front end: buffers requests, issues one strobe per request,
// returns read data through a held response. MEM_REQ_FRONTEND_STATS_EN adds wr_count/rd_count.
module mem_req_frontend #(
    parameter int DATA_WIDTH = mem_fe_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mem_fe_pkg::ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data
`ifdef MEM_REQ_FRONTEND_STATS_EN
    ,
    output logic [mem_fe_pkg::STATS_WIDTH-1:0] wr_count,
    output logic [mem_fe_pkg::STATS_WIDTH-1:0] rd_count
`endif
);

    import mem_fe_pkg::*;

    localparam int REQ_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    // Same layout as mem_req_t, sized by this instance's parameters.
    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    fe_state_e             state_q, state_d;
    req_t                  cur_q, cur_d;
    req_t                  head;
    logic [REQ_W-1:0]      head_flat;
    logic [DATA_WIDTH-1:0] rsp_q, rsp_d;
    logic                  rdy_q;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop;
    logic                  issue;

    // rdy_q keeps req_ready low through reset and until the first edge after release.
    assign req_ready = rdy_q && !fifo_full;
    assign push      = req_valid && req_ready;
    assign head      = head_flat;

    mem_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i ({req_wr, req_addr, req_wdata}),
        .pop_i       (pop),
        .pop_data_o  (head_flat),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        rsp_d   = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!cur_q.wr) begin
                    state_d = ST_RD_WAIT;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                rsp_d   = mem_rdata;
                state_d = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cur_d = pop ? head : cur_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            rsp_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rsp_q   <= rsp_d;
            rdy_q   <= 1'b1;
        end
    end

    // Memory outputs are gated by state so they read as zero outside the issue cycle.
    assign issue     = (state_q == ST_ISSUE);
    assign mem_en    = issue;
    assign mem_wr    = issue & cur_q.wr;
    assign mem_addr  = issue ? cur_q.addr  : '0;
    assign mem_wdata = issue ? cur_q.wdata : '0;
    assign rsp_valid = (state_q == ST_RSP);
    assign rsp_data  = rsp_q;

`ifdef MEM_REQ_FRONTEND_STATS_EN
    logic [STATS_WIDTH-1:0] wr_cnt_q, rd_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (issue) begin
            if (cur_q.wr) wr_cnt_q <= sat_inc(wr_cnt_q);
            else          rd_cnt_q <= sat_inc(rd_cnt_q);
        end
    end

    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;
`endif

endmodule

// File: tb/tb_mem_req_frontend.sv
// Bench for mem_req_frontend: directed scenarios plus random traffic against a
// transaction-level reference (request queue, memory array, response queue).
module tb_mem_req_frontend;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid, req_ready, req_wr;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        mem_en, mem_wr;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
`ifdef MEM_REQ_FRONTEND_STATS_EN
    logic [15:0] wr_count, rd_count;
`endif

    mem_req_frontend dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
`ifdef MEM_REQ_FRONTEND_STATS_EN
        ,
        .wr_count  (wr_count),
        .rd_count  (rd_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [36:0] exp_q[$];
    logic [31:0] rsp_exp[$];
    logic [31:0] mem_m [16];
    int          strobe_cyc[$];
    int          rsp_seen;
    int          wr_m, rd_m;
    int          rd_acc_cyc, rsp_rise, last_hs;
    logic        rdy_seen;
    logic        prev_rsp_valid;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of traffic: drive, sample at negedge, score, then advance.
    task automatic step(input logic v, input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic rr);
        logic        rd_next;
        logic [31:0] rd_data;
        logic [36:0] e;
        rd_next   = 1'b0;
        rd_data   = '0;
        req_valid = v;
        req_wr    = w;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = rr;
        @(negedge clk);
        rdy_seen = req_ready;
        if (!mem_en) begin
            chk("idle_outputs_zero", {mem_wr, mem_addr, mem_wdata}, '0);
        end else begin
            strobe_cyc.push_back(cyc);
            chk("strobe_expected", exp_q.size() > 0, 1);
            chk("strobe_while_rsp_pending", rsp_exp.size(), 0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("strobe_req", {mem_wr, mem_addr, mem_wdata}, e);
            end
            if (mem_wr) begin
                mem_m[mem_addr] = mem_wdata;
                wr_m++;
            end else begin
                rd_next = 1'b1;
                rd_data = mem_m[mem_addr];
                rsp_exp.push_back(mem_m[mem_addr]);
                rd_m++;
            end
        end
        if (rsp_valid) begin
            rsp_seen++;
            if (!prev_rsp_valid) rsp_rise = cyc;
            chk("rsp_expected", rsp_exp.size() > 0, 1);
            if (rsp_exp.size() > 0) begin
                chk("rsp_data", rsp_data, rsp_exp[0]);
                if (rr) begin
                    void'(rsp_exp.pop_front());
                    last_hs = cyc;
                end
            end
        end
        prev_rsp_valid = rsp_valid && !rr;
        if (v && req_ready) begin
            exp_q.push_back({w, a, d});
            if (!w) rd_acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        mem_rdata = rd_next ? rd_data : $urandom();
        cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first_after;
        req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
        rsp_ready = 0; mem_rdata = 0;
        prev_rsp_valid = 0; rsp_seen = 0; wr_m = 0; rd_m = 0;
        rd_acc_cyc = -100; rsp_rise = -100; last_hs = -100;
        for (int i = 0; i < 16; i++) mem_m[i] = '0;

        // reset state
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mem_out", {mem_en, mem_wr, mem_addr, mem_wdata}, '0);
        chk("rst_rsp", {rsp_valid, rsp_data}, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rdy_before_first_edge", req_ready, 0);
        @(posedge clk);
        #1;
        chk("rdy_after_first_edge", req_ready, 1);

        // write DEADBEEF to 3, read back
        step(1, 1, 4'd3, 32'hDEADBEEF, 1);
        step(1, 0, 4'd3, 32'h0, 1);
        repeat (8) step(0, 0, 0, 0, 1);
        chk("rd_latency", rsp_rise - rd_acc_cyc - 1, 3);
        chk("deadbeef_mem", mem_m[3], 32'hDEADBEEF);
        chk("deadbeef_rsp_count", rsp_seen, 1);

        // random traffic
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
                 $urandom(), ($urandom_range(0, 3) != 0));
        repeat (40) step(0, 0, 0, 0, 1);
        chk("drain_req_q", exp_q.size(), 0);
        chk("drain_rsp_q", rsp_exp.size(), 0);
        chk("idle_ready", rdy_seen, 1);

        // 5 back-to-back writes, addresses 0..4
        strobe_cyc.delete();
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 4'(i), $urandom(), 1);
            chk("b2b_ready", rdy_seen, 1);
        end
        repeat (6) step(0, 0, 0, 0, 1);
        chk("b2b_strobes", strobe_cyc.size(), 5);
        for (int i = 1; i < strobe_cyc.size(); i++)
            chk("b2b_consecutive", strobe_cyc[i] - strobe_cyc[0], i);

        // held response on addr 15, FIFO fills behind it
        step(1, 1, 4'd15, 32'hA5A55A5A, 1);
        repeat (4) step(0, 0, 0, 0, 1);
        strobe_cyc.delete();
        step(1, 0, 4'd15, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 4'(i + 8), 32'h100 + 32'(i), 0);
            chk("fill_ready", rdy_seen, 1);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 4'd12, 32'h104, 0);
            chk("full_ready_low", rdy_seen, 0);
            chk("held_rsp_valid", rsp_valid, 1);
        end
        step(1, 1, 4'd12, 32'h104, 1);
        chk("full_ready_at_hs", rdy_seen, 0);
        step(1, 1, 4'd12, 32'h104, 1);
        chk("refill_ready", rdy_seen, 1);
        repeat (10) step(0, 0, 0, 0, 1);
        first_after = -1;
        foreach (strobe_cyc[i])
            if (first_after < 0 && strobe_cyc[i] > last_hs) first_after = strobe_cyc[i];
        chk("issue_after_hs", first_after - last_hs, 1);
        chk("full_strobes", strobe_cyc.size(), 6);
        chk("full_no_loss", exp_q.size(), 0);

`ifdef MEM_REQ_FRONTEND_STATS_EN
        chk("wr_count", wr_count, 16'(wr_m > 65535 ? 65535 : wr_m));
        chk("rd_count", rd_count, 16'(rd_m > 65535 ? 65535 : rd_m));
`endif

        // reset while in RD_WAIT with two writes queued
        step(1, 0, 4'd15, 0, 0);
        step(1, 1, 4'd1, 32'h11, 0);
        step(1, 1, 4'd2, 32'h22, 0);
        reset = 1'b1;
        #1;
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_mem_out", {mem_en, mem_wr, mem_addr, mem_wdata}, '0);
        chk("midrst_rsp", {rsp_valid, rsp_data}, '0);
`ifdef MEM_REQ_FRONTEND_STATS_EN
        chk("midrst_counts", {wr_count, rd_count}, '0);
`endif
        exp_q.delete();
        rsp_exp.delete();
        prev_rsp_valid = 0;
        repeat (2) step(0, 0, 0, 0, 1);
        reset = 1'b0;
        strobe_cyc.delete();
        rsp_seen = 0;
        repeat (10) step(0, 0, 0, 0, 1);
        chk("post_rst_strobes", strobe_cyc.size(), 0);
        chk("post_rst_rsp", rsp_seen, 0);

        // short mixed burst after reset
        step(1, 1, 4'd7, 32'hCAFEF00D, 1);
        step(1, 0, 4'd7, 0, 1);
        repeat (8) step(0, 0, 0, 0, 1);
        chk("post_rst_rsp_count", rsp_seen, 1);
        chk("post_rst_drain", exp_q.size() + rsp_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
